// File: rtl/scan_sequencer.sv
// scan_sequencer: PLC-style scan-cycle controller for the VSLC core.
// Each scan snapshots inputs, fetches/executes until END_OP, commits outputs, then waits out the period.
module scan_sequencer #(
   parameter int         PC_WIDTH    = 8,
   parameter int         SCAN_PERIOD = 32,
   parameter int         MAX_INSTR   = 16,
   parameter logic [7:0] END_OP      = 8'hFF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic [7:0]          ui_in,
   output logic [7:0]          in_snap,
   output logic                stack_clr,
   output logic                fetch_req,
   output logic [PC_WIDTH-1:0] fetch_addr,
   input  logic                fetch_ack,
   input  logic [7:0]          fetch_data,
   output logic                exec_valid,
   output logic [7:0]          exec_instr,
   input  logic                exec_ready,
   input  logic                exec_jump,
   input  logic [PC_WIDTH-1:0] exec_target,
   output logic                out_commit,
   output logic [7:0]          scan_count,
   output logic                wdt_fault,
   output logic                overrun
);

   localparam int TW = $clog2(SCAN_PERIOD);
   localparam int IW = $clog2(MAX_INSTR + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SNAP   = 3'd1;
   localparam logic [2:0] S_FETCH  = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_COMMIT = 3'd4;
   localparam logic [2:0] S_WAIT   = 3'd5;

   localparam logic [TW-1:0]       T_ZERO  = {TW{1'b0}};
   localparam logic [TW-1:0]       T_ONE   = TW'(1);
   localparam logic [TW-1:0]       T_MAX   = TW'(SCAN_PERIOD - 1);
   // timer reads 0 the cycle after SNAP, so the period closes one count early to land SNAPs SCAN_PERIOD apart.
   localparam logic [TW-1:0]       T_EXIT  = TW'(SCAN_PERIOD - 2);
   localparam logic [IW-1:0]       I_ZERO  = {IW{1'b0}};
   localparam logic [IW-1:0]       I_ONE   = IW'(1);
   localparam logic [IW-1:0]       I_LAST  = IW'(MAX_INSTR - 1);
   localparam logic [PC_WIDTH-1:0] PC_ZERO = {PC_WIDTH{1'b0}};
   localparam logic [PC_WIDTH-1:0] PC_ONE  = PC_WIDTH'(1);

   logic [2:0]          state_r;
   logic [2:0]          state_s;
   logic [PC_WIDTH-1:0] pc_r;
   logic [7:0]          instr_r;
   logic [IW-1:0]       icount_r;
   logic [TW-1:0]       timer_r;
   logic                period_done_s;
   logic                in_scan_s;

   assign period_done_s = (timer_r >= T_EXIT);
   assign in_scan_s     = (state_r == S_FETCH) || (state_r == S_EXEC) || (state_r == S_COMMIT);
   assign fetch_addr    = pc_r;
   assign exec_instr    = instr_r;

   // Next-state decode of the scan sequence.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (ena) state_s = S_SNAP;
            else     state_s = S_IDLE;
         end
         S_SNAP: state_s = S_FETCH;
         S_FETCH: begin
            if (fetch_ack) begin
               if (fetch_data == END_OP) state_s = S_COMMIT;
               else                      state_s = S_EXEC;
            end else begin
               state_s = S_FETCH;
            end
         end
         S_EXEC: begin
            if (exec_ready) begin
               if (icount_r == I_LAST) state_s = S_WAIT;
               else                    state_s = S_FETCH;
            end else begin
               state_s = S_EXEC;
            end
         end
         S_COMMIT: state_s = S_WAIT;
         S_WAIT: begin
            if (period_done_s) begin
               if (ena) state_s = S_SNAP;
               else     state_s = S_IDLE;
            end else begin
               state_s = S_WAIT;
            end
         end
         default: state_s = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= S_IDLE;
      else        state_r <= state_s;
   end

   // Program counter, instruction count, period timer, counters and sticky faults.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r       <= PC_ZERO;
         instr_r    <= 8'h00;
         icount_r   <= I_ZERO;
         timer_r    <= T_ZERO;
         in_snap    <= 8'h00;
         scan_count <= 8'h00;
         wdt_fault  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (state_r == S_SNAP)   timer_r <= T_ZERO;
         else if (timer_r != T_MAX) timer_r <= timer_r + T_ONE;
         else                     timer_r <= timer_r;

         case (state_r)
            S_SNAP: begin
               in_snap  <= ui_in;
               pc_r     <= PC_ZERO;
               icount_r <= I_ZERO;
            end
            S_FETCH: begin
               if (fetch_ack) instr_r <= fetch_data;
            end
            S_EXEC: begin
               if (exec_ready) begin
                  pc_r     <= exec_jump ? exec_target : (pc_r + PC_ONE);
                  icount_r <= icount_r + I_ONE;
                  if (icount_r == I_LAST) wdt_fault <= 1'b1;
               end
            end
            S_COMMIT: scan_count <= scan_count + 8'd1;
            default: ;
         endcase

         if (in_scan_s && period_done_s) overrun <= 1'b1;
      end
   end

   // Handshake and pulse outputs registered from the next state so they align with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stack_clr  <= 1'b0;
         fetch_req  <= 1'b0;
         exec_valid <= 1'b0;
         out_commit <= 1'b0;
      end else begin
         stack_clr  <= (state_s == S_SNAP);
         fetch_req  <= (state_s == S_FETCH);
         exec_valid <= (state_s == S_EXEC);
         out_commit <= (state_s == S_COMMIT);
      end
   end

endmodule

// File: tb/tb_scan_sequencer.sv
// Testbench for scan_sequencer: acts as program memory and exec unit, checks each scan
// against a transaction-level model of addresses, instructions, commit timing and faults.
module tb_scan_sequencer;

   localparam int         P     = 40;
   localparam int         MAXI  = 16;
   localparam logic [7:0] ENDOP = 8'hFF;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] in_snap;
   logic       stack_clr;
   logic       fetch_req;
   logic [7:0] fetch_addr;
   logic       fetch_ack;
   logic [7:0] fetch_data;
   logic       exec_valid;
   logic [7:0] exec_instr;
   logic       exec_ready;
   logic       exec_jump;
   logic [7:0] exec_target;
   logic       out_commit;
   logic [7:0] scan_count;
   logic       wdt_fault;
   logic       overrun;

   scan_sequencer #(.PC_WIDTH(8), .SCAN_PERIOD(P), .MAX_INSTR(MAXI), .END_OP(ENDOP)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .in_snap(in_snap),
      .stack_clr(stack_clr), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_ack(fetch_ack), .fetch_data(fetch_data), .exec_valid(exec_valid),
      .exec_instr(exec_instr), .exec_ready(exec_ready), .exec_jump(exec_jump),
      .exec_target(exec_target), .out_commit(out_commit), .scan_count(scan_count),
      .wdt_fault(wdt_fault), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;
   int exp_sc = 0;
   bit exp_wdt = 1'b0;
   bit exp_ovr = 1'b0;
   int next_snap = -1;
   int exp_commits = 0;
   int commit_seen = 0;

   logic [7:0] mem     [256];
   bit         jmp_en  [256];
   logic [7:0] jmp_tgt [256];
   bit         used    [256];

   always @(negedge clk) if (rst_n === 1'b1 && out_commit === 1'b1) commit_seen <= commit_seen + 1;

   task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic sel(input int which);
      case (which)
         0:       return stack_clr;
         1:       return fetch_req;
         default: return exec_valid;
      endcase
   endfunction

   task automatic wait_for(input int which, input string tag);
      int n;
      n = 0;
      while (sel(which) !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      if (sel(which) !== 1'b1) begin
         check(32'(sel(which)), 32'd1, tag);
         $display("test done: total=%0d bad=%0d", total, bad);
         $fatal(1, "bounded wait expired");
      end
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) begin
         mem[i] = ENDOP; jmp_en[i] = 1'b0; jmp_tgt[i] = 8'h00; used[i] = 1'b0;
      end
   endtask

   // Random acyclic program: 1..3 instructions along a path of increments and jumps, then END.
   task automatic rand_prog();
      int a, n, t;
      clear_prog();
      a = 0;
      n = $urandom_range(3, 1);
      for (int i = 0; i < n; i++) begin
         used[a] = 1'b1;
         mem[a] = 8'($urandom_range(254, 0));
         if ($urandom_range(1, 0) == 1 || used[(a + 1) % 256]) begin
            t = $urandom_range(255, 0);
            while (used[t]) t = $urandom_range(255, 0);
            jmp_en[a] = 1'b1; jmp_tgt[a] = 8'(t); a = t;
         end else begin
            a = (a + 1) % 256;
         end
      end
      mem[a] = ENDOP;
   endtask

   // One full scan: the model walks the program, answers handshakes and predicts timing and flags.
   task automatic run_scan(input int ack_lo, input int ack_hi, input int rdy_lo, input int rdy_hi,
                           input bit drop_ena);
      int s, pc, n, lat, end_cyc;
      logic [7:0] d, snap_in;
      bit done;
      wait_for(0, "snap_timeout");
      s = cyc;
      snap_in = ui_in;
      if (next_snap >= 0) check(32'(s), 32'(next_snap), "snap_period");
      tick();
      check(32'(in_snap), 32'(snap_in), "in_snap");
      check(32'(stack_clr), 32'd0, "stack_clr_1cyc");
      check(32'(fetch_req), 32'd1, "fetch_after_snap");
      ui_in = 8'($urandom);
      pc = 0; n = 0; done = 1'b0; end_cyc = 0;
      while (!done) begin
         wait_for(1, "fetch_timeout");
         check(32'(fetch_addr), 32'(pc), "fetch_addr");
         lat = $urandom_range(ack_hi, ack_lo);
         repeat (lat) begin
            tick();
            check(32'({fetch_req, fetch_addr}), 32'({1'b1, 8'(pc)}), "fetch_hold");
         end
         d = mem[pc];
         fetch_data = d; fetch_ack = 1'b1;
         tick();
         fetch_ack = 1'b0; fetch_data = 8'($urandom);
         if (d == ENDOP) begin
            check(32'(out_commit), 32'd1, "commit_pulse");
            end_cyc = cyc;
            exp_sc = (exp_sc + 1) % 256;
            exp_commits++;
            done = 1'b1;
            tick();
         end else begin
            check(32'({exec_valid, exec_instr}), 32'({1'b1, d}), "exec_instr");
            if (drop_ena) ena = 1'b0;
            lat = $urandom_range(rdy_hi, rdy_lo);
            repeat (lat) begin
               tick();
               check(32'(exec_valid), 32'd1, "exec_hold");
            end
            exec_ready = 1'b1; exec_jump = jmp_en[pc]; exec_target = jmp_tgt[pc];
            end_cyc = cyc;
            tick();
            exec_ready = 1'b0; exec_jump = 1'($urandom); exec_target = 8'($urandom);
            n++;
            pc = jmp_en[pc] ? int'(jmp_tgt[pc]) : (pc + 1) % 256;
            if (n == MAXI) begin
               exp_wdt = 1'b1;
               done = 1'b1;
            end
         end
      end
      if (end_cyc + 2 > s + P) exp_ovr = 1'b1;
      next_snap = (end_cyc + 2 > s + P) ? end_cyc + 2 : s + P;
      check(32'(out_commit), 32'd0, "commit_1cyc");
      check(32'(scan_count), 32'(exp_sc), "scan_count");
      check(32'(wdt_fault), 32'(exp_wdt), "wdt_fault");
      check(32'(overrun), 32'(exp_ovr), "overrun");
   endtask

   initial begin
      bit seen;
      rst_n = 1'b0; ena = 1'b1; ui_in = 8'hA5;
      fetch_ack = 1'b0; fetch_data = 8'h00; exec_ready = 1'b0; exec_jump = 1'b0; exec_target = 8'h00;
      repeat (3) tick();
      check(32'({stack_clr, fetch_req, exec_valid, out_commit, wdt_fault, overrun}), 32'd0, "rst_flags");
      check(32'({in_snap, scan_count}), 32'd0, "rst_snap_count");
      check(32'({fetch_addr, exec_instr}), 32'd0, "rst_addr_instr");
      rst_n = 1'b1;
      tick();
      check(32'(stack_clr), 32'd1, "stack_clr_c1");

      // Straight-line program with immediate handshakes.
      clear_prog();
      mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = ENDOP;
      run_scan(0, 0, 0, 0, 1'b0);

      // Branch: address 1 jumps to 5.
      clear_prog();
      mem[0] = 8'h11; mem[1] = 8'h22; jmp_en[1] = 1'b1; jmp_tgt[1] = 8'h05;
      mem[2] = 8'h99; mem[5] = 8'h33; mem[6] = ENDOP;
      run_scan(0, 0, 0, 0, 1'b0);

      // Random programs and handshake latencies.
      for (int k = 0; k < 6; k++) begin
         rand_prog();
         run_scan(0, 2, 0, 2, 1'b0);
      end

      // Watchdog: every instruction jumps back to 0.
      clear_prog();
      mem[0] = 8'h01; jmp_en[0] = 1'b1; jmp_tgt[0] = 8'h00;
      run_scan(0, 0, 0, 0, 1'b0);

      // Jump to 0xFF, then increment wraps 0xFF -> 0x00.
      clear_prog();
      mem[0] = 8'h01; jmp_en[0] = 1'b1; jmp_tgt[0] = 8'hFF; mem[8'hFF] = 8'h02;
      run_scan(0, 0, 0, 0, 1'b0);

      // Overrun: slow fetches on a 4-instruction program.
      clear_prog();
      mem[0] = 8'h31; mem[1] = 8'h32; mem[2] = 8'h33; mem[3] = 8'h34;
      run_scan(10, 10, 0, 0, 1'b0);

      // Drop ena mid-scan: scan completes, then parks in IDLE.
      clear_prog();
      mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = ENDOP;
      run_scan(0, 1, 0, 1, 1'b1);
      next_snap = -1;
      seen = 1'b0;
      repeat (80) begin
         tick();
         if (stack_clr !== 1'b0 || fetch_req !== 1'b0) seen = 1'b1;
      end
      check(32'(seen), 32'd0, "idle_parked");
      check(32'(commit_seen), 32'(exp_commits), "commit_count");

      // Reset asserted while a fetch is outstanding.
      ena = 1'b1;
      wait_for(0, "snap2_timeout");
      tick();
      wait_for(1, "fetch2_timeout");
      tick();
      #2 rst_n = 1'b0;
      #1;
      check(32'(fetch_req), 32'd0, "async_fetch_drop");
      check(32'({scan_count, in_snap}), 32'd0, "async_count_snap");
      check(32'({wdt_fault, overrun}), 32'd0, "async_faults");
      tick();
      rst_n = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
